// File: rtl/sd_spi_cmd_receiver_if.sv
// SD-over-SPI command receiver bus: the serial lines from the host plus the frame-queue handshake and status.
// A frame leaves the queue on each clock where io_out_valid && io_out_ready; head fields hold while valid and not popped.
interface sd_spi_cmd_receiver_if #(parameter int ARG_WIDTH = 32);
  logic                 io_SPI_CLK;
  logic                 io_SPI_CS;
  logic                 io_SPI_DI;
  logic                 io_out_valid;
  logic                 io_out_ready;
  logic [5:0]           io_out_cmd;
  logic [ARG_WIDTH-1:0] io_out_arg;
  logic                 io_out_crc_ok;
  logic                 io_frame_err;
  logic                 io_overflow;
  logic                 io_busy;
  logic [2:0]           io_state;

  modport master (
    output io_SPI_CLK, io_SPI_CS, io_SPI_DI, io_out_ready,
    input  io_out_valid, io_out_cmd, io_out_arg, io_out_crc_ok,
           io_frame_err, io_overflow, io_busy, io_state
  );

  modport slave (
    input  io_SPI_CLK, io_SPI_CS, io_SPI_DI, io_out_ready,
    output io_out_valid, io_out_cmd, io_out_arg, io_out_crc_ok,
           io_frame_err, io_overflow, io_busy, io_state
  );
endinterface

// File: rtl/sd_spi_cmd_receiver.sv
// Receives SD SPI-mode command frames from an oversampled SPI bus and queues them (cmd, arg, crc_ok).
// Define SD_SPI_CMD_CRC_CHECK_EN to build the CRC7 checker; otherwise io_out_crc_ok is always 1.
module sd_spi_cmd_receiver #(
  parameter int ARG_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1,
  parameter int CPOL       = 0
) (
  input logic             clock,
  input logic             reset,
  sd_spi_cmd_receiver_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic CPOL_B = (CPOL != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_TBIT = 3'd1, S_CMD = 3'd2, S_ARG = 3'd3, S_CRC = 3'd4, S_END = 3'd5
  } state_t;

  // [1] is the synchronised value, sclk_q[2] the previous synchronised SPI clock
  logic [2:0] sclk_q, sclk_d;
  logic [1:0] cs_q, cs_d, di_q, di_d;
  logic       spi_edge, sample, di, cs;

  state_t               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [5:0]           cmd_q, cmd_d;
  logic [ARG_WIDTH-1:0] arg_q, arg_d;
  logic                 push_q, push_d;
  logic                 err_q, err_d;
  logic                 crc_ok_w;

  assign sclk_d   = {sclk_q[1:0], bus.io_SPI_CLK};
  assign cs_d     = {cs_q[0], bus.io_SPI_CS};
  assign di_d     = {di_q[0], bus.io_SPI_DI};
  assign spi_edge = CPOL_B ? (~sclk_q[1] & sclk_q[2]) : (sclk_q[1] & ~sclk_q[2]);
  assign cs       = cs_q[1];
  assign di       = di_q[1];
  assign sample   = spi_edge & ~cs;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    arg_d   = arg_q;
    push_d  = 1'b0;
    err_d   = 1'b0;
    if (cs) begin
      // deselect abandons any partial frame silently
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (sample) begin
      case (state_q)
        S_IDLE: if (!di) state_d = S_TBIT;
        S_TBIT: begin
          if (di) begin
            state_d = S_CMD;
            cnt_d   = 5'd5;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        S_CMD: begin
          cmd_d = (MSB_FIRST != 0) ? {cmd_q[4:0], di} : {di, cmd_q[5:1]};
          if (cnt_q == 5'd0) begin
            state_d = S_ARG;
            cnt_d   = 5'(ARG_WIDTH - 1);
          end else cnt_d = cnt_q - 5'd1;
        end
        S_ARG: begin
          arg_d = (MSB_FIRST != 0) ? {arg_q[ARG_WIDTH-2:0], di} : {di, arg_q[ARG_WIDTH-1:1]};
          if (cnt_q == 5'd0) begin
            state_d = S_CRC;
            cnt_d   = 5'd6;
          end else cnt_d = cnt_q - 5'd1;
        end
        S_CRC: begin
          if (cnt_q == 5'd0) state_d = S_END;
          else cnt_d = cnt_q - 5'd1;
        end
        S_END: begin
          state_d = S_IDLE;
          if (di) push_d = 1'b1;
          else    err_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sclk_q  <= {3{CPOL_B}};
      cs_q    <= 2'b11;
      di_q    <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      arg_q   <= '0;
      push_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      di_q    <= di_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      push_q  <= push_d;
      err_q   <= err_d;
    end
  end

`ifdef SD_SPI_CMD_CRC_CHECK_EN
  logic [6:0] crc_q, crc_d, crc_rx_q, crc_rx_d;
  logic       fb;

  // serial CRC7, x^7 + x^3 + 1, fed in transmit order
  assign fb = di ^ crc_q[6];

  always_comb begin
    crc_d    = crc_q;
    crc_rx_d = crc_rx_q;
    if (state_q == S_IDLE) crc_d = '0;
    else if (sample && (state_q == S_TBIT || state_q == S_CMD || state_q == S_ARG))
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    if (sample && state_q == S_CRC)
      crc_rx_d = (MSB_FIRST != 0) ? {crc_rx_q[5:0], di} : {di, crc_rx_q[6:1]};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      crc_q    <= '0;
      crc_rx_q <= '0;
    end else begin
      crc_q    <= crc_d;
      crc_rx_q <= crc_rx_d;
    end
  end

  assign crc_ok_w = (crc_rx_q == crc_q);
`else
  assign crc_ok_w = 1'b1;
`endif

  // frame queue; the extra pointer bit separates full from empty
  logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
  logic [5:0]           mem_cmd_q [FIFO_DEPTH], mem_cmd_d [FIFO_DEPTH];
  logic [ARG_WIDTH-1:0] mem_arg_q [FIFO_DEPTH], mem_arg_d [FIFO_DEPTH];
  logic                 mem_ok_q  [FIFO_DEPTH], mem_ok_d  [FIFO_DEPTH];
  logic                 ovf_q, ovf_d;
  logic                 empty, full, pop, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = ~empty & bus.io_out_ready;
  assign push_ok = push_q & (~full | pop);

  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    mem_cmd_d = mem_cmd_q;
    mem_arg_d = mem_arg_q;
    mem_ok_d  = mem_ok_q;
    ovf_d     = ovf_q | (push_q & full & ~pop);
    if (push_ok) begin
      mem_cmd_d[wr_q[AW-1:0]] = cmd_q;
      mem_arg_d[wr_q[AW-1:0]] = arg_q;
      mem_ok_d[wr_q[AW-1:0]]  = crc_ok_w;
      wr_d = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    mem_cmd_q <= mem_cmd_d;
    mem_arg_q <= mem_arg_d;
    mem_ok_q  <= mem_ok_d;
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.io_out_valid  = ~empty;
  assign bus.io_out_cmd    = empty ? 6'd0 : mem_cmd_q[rd_q[AW-1:0]];
  assign bus.io_out_arg    = empty ? '0 : mem_arg_q[rd_q[AW-1:0]];
  assign bus.io_out_crc_ok = empty ? 1'b0 : mem_ok_q[rd_q[AW-1:0]];
  assign bus.io_frame_err  = err_q;
  assign bus.io_overflow   = ovf_q;
  assign bus.io_busy       = (state_q != S_IDLE);
  assign bus.io_state      = state_q;
endmodule

// File: tb/tb_sd_spi_cmd_receiver.sv
// Directed bench for sd_spi_cmd_receiver: an MSB-first instance for most scenarios and an LSB-first one.
module tb_sd_spi_cmd_receiver;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic spi_clk = 1'b0;
  logic spi_di  = 1'b1;
  logic cs0     = 1'b1;
  logic cs1     = 1'b1;

  int vectors = 0;
  int fails   = 0;
  int err0    = 0;

`ifdef SD_SPI_CMD_CRC_CHECK_EN
  localparam logic EXP_OK_BADCRC = 1'b0;
`else
  localparam logic EXP_OK_BADCRC = 1'b1;
`endif

  sd_spi_cmd_receiver_if #(.ARG_WIDTH(32)) if0 ();
  sd_spi_cmd_receiver_if #(.ARG_WIDTH(32)) if1 ();

  assign if0.io_SPI_CLK = spi_clk;
  assign if0.io_SPI_DI  = spi_di;
  assign if0.io_SPI_CS  = cs0;
  assign if1.io_SPI_CLK = spi_clk;
  assign if1.io_SPI_DI  = spi_di;
  assign if1.io_SPI_CS  = cs1;

  sd_spi_cmd_receiver #(.ARG_WIDTH(32), .FIFO_DEPTH(4), .MSB_FIRST(1), .CPOL(0))
    u_msb (.clock(clock), .reset(reset), .bus(if0.slave));
  sd_spi_cmd_receiver #(.ARG_WIDTH(32), .FIFO_DEPTH(4), .MSB_FIRST(0), .CPOL(0))
    u_lsb (.clock(clock), .reset(reset), .bus(if1.slave));

  always @(negedge clock) if (if0.io_frame_err === 1'b1) err0++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    spi_di = b;
    repeat (4) @(posedge clock);
    spi_clk = 1'b1;
    repeat (8) @(posedge clock);
    spi_clk = 1'b0;
    repeat (4) @(posedge clock);
  endtask

  // transmits the first nbits of f, starting at f[47]
  task automatic send_frame(input bit sel, input logic [47:0] f, input int nbits);
    if (sel) cs1 = 1'b0; else cs0 = 1'b0;
    repeat (4) @(posedge clock);
    for (int i = 0; i < nbits; i++) send_bit(f[47-i]);
    repeat (4) @(posedge clock);
    if (sel) cs1 = 1'b1; else cs0 = 1'b1;
    spi_di = 1'b1;
    repeat (8) @(posedge clock);
  endtask

  task automatic wait_valid(input bit sel, input string tag);
    int k;
    k = 0;
    @(negedge clock);
    while (((sel ? if1.io_out_valid : if0.io_out_valid) !== 1'b1) && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 64'(sel ? if1.io_out_valid : if0.io_out_valid), 64'd1);
  endtask

  task automatic pop(input bit sel);
    @(negedge clock);
    if (sel) if1.io_out_ready = 1'b1; else if0.io_out_ready = 1'b1;
    @(negedge clock);
    if (sel) if1.io_out_ready = 1'b0; else if0.io_out_ready = 1'b0;
  endtask

  logic [47:0] f;
  logic [5:0]  lcmd;
  logic [31:0] larg;
  int          e;

  initial begin
    if0.io_out_ready = 1'b0;
    if1.io_out_ready = 1'b0;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", 64'(if0.io_out_valid), 64'd0);
    chk("rst_state", 64'(if0.io_state), 64'd0);
    chk("rst_busy", 64'(if0.io_busy), 64'd0);
    chk("rst_ovf", 64'(if0.io_overflow), 64'd0);
    chk("rst_cmd", 64'(if0.io_out_cmd), 64'd0);
    chk("rst_arg", 64'(if0.io_out_arg), 64'd0);
    chk("rst_crc_ok", 64'(if0.io_out_crc_ok), 64'd0);
    chk("rst_frame_err", 64'(if0.io_frame_err), 64'd0);
    reset = 1'b1;
    repeat (5) @(posedge clock);

    // CMD0 with its canonical CRC
    send_frame(1'b0, 48'h40_00000000_95, 48);
    wait_valid(1'b0, "cmd0_valid");
    chk("cmd0_cmd", 64'(if0.io_out_cmd), 64'd0);
    chk("cmd0_arg", 64'(if0.io_out_arg), 64'd0);
    chk("cmd0_crc_ok", 64'(if0.io_out_crc_ok), 64'd1);
    pop(1'b0);
    chk("cmd0_drained", 64'(if0.io_out_valid), 64'd0);
    chk("cmd0_no_err", 64'(err0), 64'd0);

    // CMD8 good and bad CRC
    send_frame(1'b0, 48'h48_000001AA_87, 48);
    wait_valid(1'b0, "cmd8_valid");
    chk("cmd8_cmd", 64'(if0.io_out_cmd), 64'd8);
    chk("cmd8_arg", 64'(if0.io_out_arg), 64'h1AA);
    chk("cmd8_crc_ok", 64'(if0.io_out_crc_ok), 64'd1);
    pop(1'b0);
    send_frame(1'b0, 48'h48_000001AA_89, 48);
    wait_valid(1'b0, "cmd8bad_valid");
    chk("cmd8bad_cmd", 64'(if0.io_out_cmd), 64'd8);
    chk("cmd8bad_crc_ok", 64'(if0.io_out_crc_ok), 64'(EXP_OK_BADCRC));
    pop(1'b0);

    // start bit then transmission bit 0
    e = err0;
    send_frame(1'b0, 48'h0, 2);
    chk("tbit_err_pulse", 64'(err0 - e), 64'd1);
    chk("tbit_state", 64'(if0.io_state), 64'd0);
    chk("tbit_no_entry", 64'(if0.io_out_valid), 64'd0);

    // end bit 0
    e = err0;
    send_frame(1'b0, 48'h40_00000000_94, 48);
    chk("endbit_err_pulse", 64'(err0 - e), 64'd1);
    chk("endbit_no_entry", 64'(if0.io_out_valid), 64'd0);

    // CS released after 20 bits of CMD8, then a complete CMD0
    e = err0;
    send_frame(1'b0, 48'h48_000001AA_87, 20);
    chk("abort_state", 64'(if0.io_state), 64'd0);
    chk("abort_no_entry", 64'(if0.io_out_valid), 64'd0);
    send_frame(1'b0, 48'h40_00000000_95, 48);
    wait_valid(1'b0, "abort_cmd0_valid");
    chk("abort_cmd0_cmd", 64'(if0.io_out_cmd), 64'd0);
    pop(1'b0);
    chk("abort_only_one", 64'(if0.io_out_valid), 64'd0);
    chk("abort_no_err", 64'(err0 - e), 64'd0);

    // five CMD0 frames with no consumer; args tag the order
    for (int i = 1; i <= 5; i++) begin
      send_frame(1'b0, {8'h40, 32'(i), 8'h01}, 48);
      if (i == 4) chk("ovf_before", 64'(if0.io_overflow), 64'd0);
    end
    repeat (4) @(negedge clock);
    chk("ovf_after", 64'(if0.io_overflow), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      wait_valid(1'b0, "drain_valid");
      chk("drain_arg", 64'(if0.io_out_arg), 64'(i));
      pop(1'b0);
    end
    chk("drain_empty", 64'(if0.io_out_valid), 64'd0);
    chk("ovf_sticky", 64'(if0.io_overflow), 64'd1);

    // LSB-first cmd 59, arg 128913
    lcmd = 6'd59;
    larg = 32'd128913;
    f = '0;
    f[46] = 1'b1;
    for (int j = 0; j < 6; j++) f[45-j] = lcmd[j];
    for (int j = 0; j < 32; j++) f[39-j] = larg[j];
    f[0] = 1'b1;
    send_frame(1'b1, f, 48);
    wait_valid(1'b1, "lsb_valid");
    chk("lsb_cmd", 64'(if1.io_out_cmd), 64'd59);
    chk("lsb_arg", 64'(if1.io_out_arg), 64'h1F791);
    pop(1'b1);

    // reset in mid-frame with an entry queued
    send_frame(1'b0, 48'h40_00000000_95, 48);
    wait_valid(1'b0, "pre_rst_valid");
    cs0 = 1'b0;
    repeat (4) @(posedge clock);
    for (int i = 0; i < 10; i++) send_bit(1'b0 ^ (i == 1));
    reset = 1'b0;
    repeat (3) @(posedge clock);
    reset = 1'b1;
    cs0 = 1'b1;
    spi_di = 1'b1;
    @(negedge clock);
    chk("midrst_valid", 64'(if0.io_out_valid), 64'd0);
    chk("midrst_state", 64'(if0.io_state), 64'd0);
    chk("midrst_ovf", 64'(if0.io_overflow), 64'd0);
    repeat (8) @(posedge clock);
    send_frame(1'b0, 48'h48_000001AA_87, 48);
    wait_valid(1'b0, "postrst_valid");
    chk("postrst_cmd", 64'(if0.io_out_cmd), 64'd8);
    chk("postrst_arg", 64'(if0.io_out_arg), 64'h1AA);
    pop(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
